// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: sequencing controller for a 5-stage RISC-V pipeline.
// Drives the PC and IF/ID write enables, the IF/ID flush and the ID-stage
// bubble request. It handles load-use stalls, taken-branch flushes, start-up
// from idle, and the end-of-program drain that comes before o_finish.
// Optional feature: define PIPE_HAZARD_PERF_EN to add saturating performance
// counters (o_cyc_cnt, o_stall_cnt, o_flush_cnt, each CNT_W bits wide).
module pipeline_hazard_ctrl #(
  parameter int unsigned DRAIN_CYCLES = 3,  // legal 1..15
  parameter int unsigned CNT_W        = 32
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_start,
  input  logic       i_id_valid,
  input  logic [6:0] i_id_opcode,
  input  logic [4:0] i_id_rs1,
  input  logic [4:0] i_id_rs2,
  input  logic       i_ex_memRead,
  input  logic [4:0] i_ex_rd,
  input  logic       i_ex_branch_taken,
  output logic       o_pc_we,
  output logic       o_pc_sel,
  output logic       o_ifid_we,
  output logic       o_ifid_flush,
  output logic       o_nop,
  output logic       o_busy,
  output logic       o_finish
`ifdef PIPE_HAZARD_PERF_EN
  ,
  output logic [CNT_W-1:0] o_cyc_cnt,
  output logic [CNT_W-1:0] o_stall_cnt,
  output logic [CNT_W-1:0] o_flush_cnt
`endif
);

  localparam logic [6:0] OP_LD      = 7'b0000011;
  localparam logic [6:0] OP_SD      = 7'b0100011;
  localparam logic [6:0] OP_BRANCH  = 7'b1100011;
  localparam logic [6:0] OP_ALU_IMM = 7'b0010011;
  localparam logic [6:0] OP_ALU     = 7'b0110011;
  localparam logic [6:0] OP_DONE    = 7'b1111111;

  // Counter value loaded on DONE accept. It reaches zero in the last DRAIN
  // cycle, so o_finish rises DRAIN_CYCLES edges after the accept edge.
  localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_HALT  = 2'd3
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] drain_cnt_q, drain_cnt_d;
  logic       finish_q, finish_d;

  logic uses_rs1;
  logic uses_rs2;
  logic load_use;
  logic stall_cyc;
  logic flush_cyc;

  // Decide which source registers the ID instruction reads, then detect a
  // load-use dependency on the load currently in EX.
  // NOTE: every signal assigned in an always_comb gets a default value first,
  // so no path through the block can leave it unassigned and infer a latch.
  always_comb begin
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    case (i_id_opcode)
      OP_LD, OP_ALU_IMM:    uses_rs1 = 1'b1;
      OP_SD, OP_BRANCH, OP_ALU: begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
      end
      default: ;
    endcase
    load_use = i_id_valid && i_ex_memRead && (i_ex_rd != 5'd0) &&
               ((uses_rs1 && (i_ex_rd == i_id_rs1)) ||
                (uses_rs2 && (i_ex_rd == i_id_rs2)));
  end

  // Next-state logic and pipeline control outputs, which are combinational
  // from the current state and the inputs.
  always_comb begin
    state_d      = state_q;
    drain_cnt_d  = drain_cnt_q;
    finish_d     = finish_q;
    o_pc_we      = 1'b0;
    o_pc_sel     = 1'b0;
    o_ifid_we    = 1'b0;
    o_ifid_flush = 1'b0;
    o_nop        = 1'b1;
    stall_cyc    = 1'b0;
    flush_cyc    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (i_start) state_d = ST_RUN;
      end

      ST_RUN: begin
        if (i_ex_branch_taken) begin
          // A taken branch squashes whatever sits in ID, including a DONE
          // or an instruction that would otherwise stall.
          o_pc_we      = 1'b1;
          o_pc_sel     = 1'b1;
          o_ifid_we    = 1'b1;
          o_ifid_flush = 1'b1;
          flush_cyc    = 1'b1;
        end else if (load_use) begin
          // Hold PC and IF/ID for one cycle and insert a bubble. On the next
          // cycle the load is in MEM, so the hazard is gone.
          stall_cyc = 1'b1;
        end else if (i_id_valid && (i_id_opcode == OP_DONE)) begin
          // DONE goes to the control unit exactly once. Fetch then freezes.
          o_nop       = 1'b0;
          drain_cnt_d = DRAIN_LOAD;
          state_d     = ST_DRAIN;
        end else begin
          o_pc_we   = 1'b1;
          o_ifid_we = 1'b1;
          o_nop     = 1'b0;
        end
      end

      ST_DRAIN: begin
        // Branches are ignored here: every instruction older than DONE has
        // already left EX.
        if (drain_cnt_q == 4'd0) begin
          state_d  = ST_HALT;
          finish_d = 1'b1;
        end else begin
          drain_cnt_d = drain_cnt_q - 4'd1;
        end
      end

      ST_HALT: ;

      default: state_d = ST_IDLE;
    endcase
  end

  assign o_busy   = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign o_finish = finish_q;

  // State, drain counter and sticky finish flag.
  // NOTE: sequential blocks use non-blocking assignments only. Every flop then
  // samples values from before the edge, so the result does not depend on
  // the order in which blocks are evaluated.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= ST_IDLE;
      drain_cnt_q <= 4'd0;
      finish_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
      finish_q    <= finish_d;
    end
  end

`ifdef PIPE_HAZARD_PERF_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cyc_cnt_q, cyc_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  // Saturating event counters. They are cleared only by reset.
  always_comb begin
    cyc_cnt_d   = cyc_cnt_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (o_busy && (cyc_cnt_q != CNT_MAX))       cyc_cnt_d   = cyc_cnt_q + 1'b1;
    if (stall_cyc && (stall_cnt_q != CNT_MAX))  stall_cnt_d = stall_cnt_q + 1'b1;
    if (flush_cyc && (flush_cnt_q != CNT_MAX))  flush_cnt_d = flush_cnt_q + 1'b1;
  end

  // Performance counter registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cyc_cnt_q   <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      cyc_cnt_q   <= cyc_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign o_cyc_cnt   = cyc_cnt_q;
  assign o_stall_cnt = stall_cnt_q;
  assign o_flush_cnt = flush_cnt_q;
`endif

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Sequencing controller for the 5-stage RISC-V pipeline; sits beside the decode-stage control unit.
- Owns PC/IF-ID write enables, IF/ID flush and the ID-stage bubble request (drives the control unit's i_nop).
- Handles load-use stalls, taken-branch flushes, start-up from idle, and end-of-program drain before reporting finish.

Parameters:
- DRAIN_CYCLES, 3, cycles spent in DRAIN after DONE is accepted in ID before o_finish rises (covers EX/MEM/WB); legal 1..15.
- CNT_W, 32, width of performance counters (optional feature only).

Ports:
- i_clk  input  1  clock, rising edge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_start  input  1  single-cycle pulse; leaves IDLE.
- i_id_valid  input  1  IF/ID register holds a real instruction.
- i_id_opcode  input  7  opcode in ID.
- i_id_rs1  input  5  rs1 field in ID.
- i_id_rs2  input  5  rs2 field in ID.
- i_ex_memRead  input  1  instruction in EX is a load.
- i_ex_rd  input  5  destination register of EX instruction.
- i_ex_branch_taken  input  1  branch in EX resolved taken.
- o_pc_we  output  1  PC register write enable.
- o_pc_sel  output  1  1 = load branch target, 0 = PC+4.
- o_ifid_we  output  1  IF/ID register write enable.
- o_ifid_flush  output  1  clear IF/ID valid on next edge.
- o_nop  output  1  bubble request to control unit (zeroes ID/EX controls).
- o_busy  output  1  state is RUN or DRAIN.
- o_finish  output  1  registered, sticky until reset.

Behaviour:
- Opcodes: LD 0000011, SD 0100011, BRANCH 1100011, ALU_IMM 0010011, ALU 0110011, DONE 1111111.
- States: IDLE, RUN, DRAIN, HALT. Reset → IDLE, drain counter 0, o_finish 0.
- Outputs are combinational from state and inputs. o_finish is a flop, set on entry to HALT.
- IDLE:
  - o_pc_we=0, o_ifid_we=0, o_nop=1, o_ifid_flush=0, o_pc_sel=0.
  - i_start → RUN next cycle.
- RUN priority, highest first:
  - Branch: i_ex_branch_taken=1 → o_pc_we=1, o_pc_sel=1, o_ifid_we=1, o_ifid_flush=1, o_nop=1. Squashes any hazard or DONE in ID the same cycle; stays RUN.
  - Load-use: all of the following hold → o_pc_we=0, o_ifid_we=0, o_nop=1, stays RUN.
    - i_id_valid=1, i_ex_memRead=1, i_ex_rd≠0.
    - i_ex_rd==i_id_rs1 for opcodes LD/SD/BRANCH/ALU_IMM/ALU, or i_ex_rd==i_id_rs2 for opcodes SD/BRANCH/ALU.
    - Exactly one bubble per hazard: the next cycle has the load in MEM.
  - DONE: i_id_valid=1 and i_id_opcode==DONE → o_pc_we=0, o_ifid_we=0, o_nop=0 (DONE passes to control unit once).
    - Load drain counter with DRAIN_CYCLES-1; → DRAIN.
  - Otherwise: o_pc_we=1, o_pc_sel=0, o_ifid_we=1, o_ifid_flush=0, o_nop=0.
  - Unknown opcode with i_id_valid=1: no hazard check on either rs field; normal advance.
- DRAIN:
  - o_pc_we=0, o_ifid_we=0, o_nop=1. i_ex_branch_taken is ignored (no older branch can remain in EX).
  - Counter decrements each cycle. At 0 → HALT and o_finish←1 on that edge.
  - Total cycles from the DONE-accept edge to o_finish=1: DRAIN_CYCLES.
- HALT:
  - Same outputs as IDLE; i_start ignored; o_finish held 1.
- Reset asserted in any state forces IDLE, outputs to IDLE values, o_finish=0 immediately (asynchronous).
- i_start outside IDLE: ignored.

Optional Feature:
- Macro PIPE_HAZARD_PERF_EN.
- Defined: adds outputs o_cyc_cnt, o_stall_cnt, o_flush_cnt, each CNT_W bits.
  - o_cyc_cnt: +1 every cycle in RUN or DRAIN.
  - o_stall_cnt: +1 per load-use bubble cycle.
  - o_flush_cnt: +1 per taken-branch cycle.
  - All saturate at all-ones and clear on reset only.
- Undefined: ports and logic absent; all other behaviour identical.

Test Plan:
- Reset, then i_start pulse → IDLE outputs before the pulse; cycle after the pulse o_pc_we=1, o_busy=1, o_nop=0.
- RUN, EX LD rd=5, ID ALU rs2=5 → exactly 1 cycle o_pc_we=0/o_ifid_we=0/o_nop=1, then normal; repeat with rd=0 → no stall; with ID ALU_IMM using rs2-field=5 → no stall.
- Same cycle: i_ex_branch_taken=1 and a load-use hazard → o_pc_sel=1, o_ifid_flush=1, o_nop=1, o_pc_we=1 (branch wins, no stall).
- ID DONE, DRAIN_CYCLES=3 → o_finish=1 exactly 3 cycles after accept edge; o_nop=0 only on accept cycle; o_finish stays 1 for 10 cycles, ignores i_start.
- DONE in ID with i_ex_branch_taken=1 → flush, remain RUN, no finish; then assert i_rst_n=0 mid-DRAIN → o_finish=0, IDLE immediately.
- With PIPE_HAZARD_PERF_EN, CNT_W=4: 20 running cycles → o_cyc_cnt=15 (saturated); 2 stalls, 1 flush → o_stall_cnt=2, o_flush_cnt=1.
